decrypt_stream_ctrl: RTL and testbench
======================================

// Module: decrypt_stream_ctrl
// PURPOSE
//  Sequencer for the decryption datapath around the I/O memory. On start it walks a range
//  of 128-bit encrypted ROM entries, hands each to the external cipher unit over a
//  valid/ready handshake, and writes each 64-bit result into the decrypted VRAM.
//  It processes one block at a time, then pulses done. The processor runs it via start/busy/done.
// PARAMETERS
//  ADDR_W      32   width of all address ports and base registers
//  CNT_W       16   width of block_count and the internal block index
//  ROM_LAT     1    encrypted ROM read latency in clk cycles (>=1)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       start request, sampled only in IDLE
//  src_base     in   ADDR_W  first encrypted ROM entry index, captured at start
//  dst_base     in   ADDR_W  first decrypted VRAM entry index, captured at start
//  block_count  in   CNT_W   number of blocks, captured at start
//  busy         out  1       high in every state except IDLE
//  done         out  1       one-cycle pulse when the sequence completes
//  rom_addr     out  ADDR_W  encrypted ROM read address
//  rom_data     in   128     encrypted ROM read data, valid ROM_LAT cycles after rom_addr
//  cip_valid    out  1       block offered to cipher unit
//  cip_data     out  128     block to cipher unit
//  cip_ready    in   1       cipher unit accepts block
//  res_valid    in   1       cipher result available
//  res_data     in   64      cipher result
//  res_ready    out  1       controller accepts result
//  vram_addr    out  ADDR_W  decrypted VRAM write address
//  vram_wdata   out  64      decrypted VRAM write data
//  vram_we      out  1       decrypted VRAM write enable, one cycle per block
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy, done, cip_valid, res_ready, vram_we = 0;
//   rom_addr, cip_data, vram_addr, vram_wdata, index = 0. Reset mid-sequence abandons it with no done pulse.
//  States: IDLE, FETCH, ISSUE, WAIT_RES, WRITE, DONE. idx = block index, 0..block_count-1.
//  IDLE: when start=1, capture src_base/dst_base/block_count and set idx=0.
//   Go to DONE if block_count==0, otherwise go to FETCH. start in any other state is ignored.
//  FETCH: rom_addr = src_base+idx. Stay exactly ROM_LAT cycles.
//   At the edge ending the last FETCH cycle, register rom_data into cip_data and go to ISSUE.
//  ISSUE: cip_valid=1. cip_data is held stable until cip_valid&cip_ready; then go to WAIT_RES.
//  WAIT_RES: res_ready=1. On res_valid, register res_data into vram_wdata and go to WRITE.
//   res_valid outside WAIT_RES is not consumed (res_ready=0).
//  WRITE: vram_we=1 for exactly one cycle; vram_addr=dst_base+idx.
//   If idx==block_count-1 go to DONE; otherwise idx++ and go to FETCH.
//  DONE: done=1 for one cycle, then go to IDLE. busy is still 1 in DONE and drops in IDLE.
//  Address arithmetic is unsigned modulo 2^ADDR_W, so base+idx wraps with no error.
//  Throughput with zero-wait handshakes: ROM_LAT+3 cycles per block.
//  rom_addr holds its last value outside FETCH. vram_addr and vram_wdata are don't-care when vram_we=0.
// TESTING
//  T1 ROM_LAT=1, src=0x10, dst=0x40, count=3, cip_ready=res_valid=1, start at edge 0 ->
//     vram_we in cycles 4, 8 and 12 at 0x40, 0x41 and 0x42, with res_data for rom entries 0x10..0x12.
//     done=1 only in cycle 13; busy=1 in cycles 1..13.
//  T2 count=0, start -> done=1 in cycle 1; no vram_we and no cip_valid; busy=0 from cycle 2.
//  T3 cip_ready held low for 5 cycles in ISSUE -> cip_valid=1 and cip_data unchanged for all
//     5 cycles; transfer completes the cycle cip_ready rises. Repeat with res_valid delayed 4 cycles
//     -> res_ready stays 1 and no vram_we until res_valid.
//  T4 src=0xFFFF_FFFF, dst=0xFFFF_FFFE, count=3 -> rom_addr FFFF_FFFF, 0, 1;
//     vram_addr FFFF_FFFE, FFFF_FFFF, 0.
//  T5 start pulsed again during WAIT_RES with different bases -> ignored; the original sequence
//     completes with the original addresses and exactly one done pulse.
//  T6 rst_n low mid-WRITE (async, between edges) -> vram_we, busy and cip_valid drop immediately; no done.
//     After release, a new start with count=1 runs a clean single-block sequence.

Source files
------------

// File: rtl/decrypt_stream_ctrl.sv
// Block-at-a-time decryption sequencer: encrypted ROM -> cipher unit -> decrypted VRAM.
// Driven by the processor through start/busy/done.
module decrypt_stream_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  block_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [127:0]      rom_data,
  output logic              cip_valid,
  output logic [127:0]      cip_data,
  input  logic              cip_ready,
  input  logic              res_valid,
  input  logic [63:0]       res_data,
  output logic              res_ready,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [63:0]       vram_wdata,
  output logic              vram_we,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_RES = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int                LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ROM_LAT - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic              last_blk;
  logic [CNT_W-1:0]  idx_next;

  assign last_blk  = (idx == cnt_q - CNT_ONE);
  assign idx_next  = idx + CNT_ONE;
  assign dbg_state = state;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // cip_valid/cip_data are held until that edge; res_ready is high only in WAIT_RES, so
  // a res_valid seen in any other state is left pending at the cipher unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cip_valid  <= 1'b0;
      res_ready  <= 1'b0;
      vram_we    <= 1'b0;
      rom_addr   <= '0;
      cip_data   <= '0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      idx        <= '0;
      lat_cnt    <= '0;
    end else begin
      done    <= 1'b0;
      vram_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q <= src_base;
            dst_q <= dst_base;
            cnt_q <= block_count;
            idx   <= '0;
            busy  <= 1'b1;
            if (block_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_FETCH;
              rom_addr <= src_base;
              lat_cnt  <= '0;
            end
          end
        end
        S_FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            cip_data  <= rom_data;
            cip_valid <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            lat_cnt <= lat_cnt + LAT_ONE;
          end
        end
        S_ISSUE: begin
          if (cip_ready) begin
            cip_valid <= 1'b0;
            res_ready <= 1'b1;
            state     <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (res_valid) begin
            res_ready  <= 1'b0;
            vram_wdata <= res_data;
            vram_addr  <= dst_q + ADDR_W'(idx);
            vram_we    <= 1'b1;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (last_blk) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            idx      <= idx_next;
            rom_addr <= src_q + ADDR_W'(idx_next);
            lat_cnt  <= '0;
            state    <= S_FETCH;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_stream_ctrl.sv
// Bench for decrypt_stream_ctrl: ROM and cipher-unit models, a VRAM-write scoreboard,
// and directed timing/handshake/wrap/reset scenarios.
module tb_decrypt_stream_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int W      = ADDR_W + 64;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [CNT_W-1:0]  block_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [127:0]      rom_data;
  logic              cip_valid;
  logic [127:0]      cip_data;
  logic              cip_ready;
  logic              res_valid;
  logic [63:0]       res_data;
  logic              res_ready;
  logic [ADDR_W-1:0] vram_addr;
  logic [63:0]       vram_wdata;
  logic              vram_we;
  logic [2:0]        dbg_state;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0]       we_m, done_m, busy_m, cv_m;
  logic [ADDR_W-1:0] ra[3];

  decrypt_stream_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ROM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .block_count(block_count), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_data(rom_data), .cip_valid(cip_valid), .cip_data(cip_data), .cip_ready(cip_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- models ----------------
  function automatic logic [127:0] rom_word(input logic [ADDR_W-1:0] a);
    return {a ^ 32'h1111_1111, ~a, a + 32'h0100_0000, a};
  endfunction

  function automatic logic [63:0] cipher_fn(input logic [127:0] b);
    return b[127:64] ^ b[63:0];
  endfunction

  assign rom_data = rom_word(rom_addr);

  logic [63:0] held_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) held_res <= '0;
    else if (cip_valid && cip_ready) held_res <= cipher_fn(cip_data);
  end
  assign res_data = held_res;

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (rst_n && vram_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vram_write: unexpected write addr=%h data=%h", vram_addr, vram_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({vram_addr, vram_wdata} !== e) begin
          errors++;
          $display("FAIL vram_write: got addr=%h data=%h, expected addr=%h data=%h",
                   vram_addr, vram_wdata, e[W-1:64], e[63:0]);
        end
      end
    end
  end

  always @(negedge clk) if (rst_n && done) done_cnt++;

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_blocks(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({d + ADDR_W'(i), cipher_fn(rom_word(s + ADDR_W'(i)))});
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input logic [CNT_W-1:0] n);
    @(negedge clk);
    src_base    = s;
    dst_base    = d;
    block_count = n;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check({name, "_done_seen"}, 128'(k < budget), 128'(1));
  endtask

  task automatic timed_run(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input int n, input int ncyc);
    we_m = '0; done_m = '0; busy_m = '0; cv_m = '0;
    push_blocks(s, d, n);
    pulse_start(s, d, CNT_W'(n));
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      we_m[c]   = vram_we;
      done_m[c] = done;
      busy_m[c] = busy;
      cv_m[c]   = cip_valid;
      if (c == 1 || c == 5 || c == 9) ra[c / 4] = rom_addr;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int d0;
    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; block_count = '0;
    cip_ready = 1'b1; res_valid = 1'b1;
    #12;
    check("rst_busy",      128'(busy), 128'(0));
    check("rst_done",      128'(done), 128'(0));
    check("rst_cip_valid", 128'(cip_valid), 128'(0));
    check("rst_res_ready", 128'(res_ready), 128'(0));
    check("rst_vram_we",   128'(vram_we), 128'(0));
    check("rst_regs",      128'({rom_addr, vram_addr, vram_wdata}), 128'(0));
    check("rst_cip_data",  cip_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // T1: three back-to-back blocks, zero-wait handshakes
    timed_run(32'h10, 32'h40, 3, 15);
    check("t1_we_cycles",   128'(we_m),   128'(32'h0000_1110));
    check("t1_done_cycles", 128'(done_m), 128'(32'h0000_2000));
    check("t1_busy_cycles", 128'(busy_m), 128'(32'h0000_3FFE));
    check("t1_cv_cycles",   128'(cv_m),   128'(32'h0000_0444));
    idle(2);

    // T2: zero blocks
    timed_run(32'h10, 32'h40, 0, 4);
    check("t2_done_cycles", 128'(done_m), 128'(32'h2));
    check("t2_busy_cycles", 128'(busy_m), 128'(32'h2));
    check("t2_no_we",       128'(we_m),   128'(0));
    check("t2_no_cv",       128'(cv_m),   128'(0));
    idle(2);

    // T3: cipher stalls for 5 cycles, then result delayed 4 cycles
    cip_ready = 1'b0;
    res_valid = 1'b0;
    push_blocks(32'h80, 32'h90, 1);
    pulse_start(32'h80, 32'h90, 16'd1);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cip_valid) break;
    end
    check("t3_issue_seen", 128'(k < 10), 128'(1));
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check("t3_cv_held",   128'(cip_valid), 128'(1));
      check("t3_data_held", cip_data, rom_word(32'h80));
    end
    cip_ready = 1'b1;
    @(negedge clk);
    check("t3_cv_dropped", 128'({cip_valid, res_ready}), 128'(2'b01));
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      check("t3_wait_res", 128'({res_ready, vram_we}), 128'(2'b10));
    end
    res_valid = 1'b1;
    @(negedge clk);
    check("t3_we_after_res", 128'(vram_we), 128'(1));
    wait_done("t3", 10);
    idle(2);

    // T4: address wrap at 2^32
    timed_run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, 14);
    check("t4_rom_addr0", 128'(ra[0]), 128'(32'hFFFF_FFFF));
    check("t4_rom_addr1", 128'(ra[1]), 128'(32'h0000_0000));
    check("t4_rom_addr2", 128'(ra[2]), 128'(32'h0000_0001));
    check("t4_done",      128'(done_m), 128'(32'h0000_2000));
    idle(2);

    // T5: start during WAIT_RES is ignored
    push_blocks(32'h200, 32'h300, 2);
    pulse_start(32'h200, 32'h300, 16'd2);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_ready) break;
    end
    check("t5_wait_res_seen", 128'(k < 10), 128'(1));
    src_base = 32'h999; dst_base = 32'h777; block_count = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    d0 = done_cnt;
    wait_done("t5", 20);
    idle(12);
    check("t5_single_done", 128'(done_cnt - d0), 128'(1));
    check("t5_idle_after",  128'(busy), 128'(0));

    // T6: async reset in the middle of WRITE
    push_blocks(32'h500, 32'h600, 1);
    pulse_start(32'h500, 32'h600, 16'd2);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (vram_we) break;
    end
    check("t6_write_seen", 128'(k < 10), 128'(1));
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_drop", 128'({vram_we, busy, cip_valid}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check("t6_no_done", 128'(done_cnt - d0), 128'(0));
    push_blocks(32'h20, 32'h30, 1);
    pulse_start(32'h20, 32'h30, 16'd1);
    wait_done("t6b", 10);
    idle(3);

    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    check("final_done_count",  128'(done_cnt), 128'(6));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
